// File: rtl/spc_reg_bank.sv
// spc_reg_bank: parametrised special-register bank for the single-cycle computer.
//
// Holds a hardwired zero register, the stack pointer, link register, program
// counter and CPSR, plus general-purpose entries. Provides a PC sequencer, SP
// push/pop with floor/ceiling checks, masked NZCV flag updates and single-level
// exception entry/return with shadowed PC and CPSR.
//
// Register map: 0 ZR, 4 SP, 5 LR, 6 PC, 7 CPSR; every other index is general.
// CPSR layout: [DATA_W-1:DATA_W-4] = N,Z,C,V; [0] = exception mode.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   usr_wr_en/addr/data        user write port (lowest priority on special entries)
//   usr_rd_addr, usr_rd_data   combinational user read of current state
//   pc_mode, pc_load_data      00 hold, 01 advance, 10 load, 11 hold
//   sp_op                      00 none, 01 push, 10 pop, 11 none
//   lr_wr_en, lr_wr_data       link write (beats the user port)
//   flag_wr_mask/data          per-flag NZCV update (bit3 N .. bit0 V)
//   exc_enter, exc_return      exception entry / return requests
//   pc_out, sp_out, lr_out, cpsr_out   direct register views
//   in_exception               CPSR[0]
//   stack_fault                one-cycle pulse on a rejected push/pop
//   exc_nested                 one-cycle pulse when exc_enter is ignored
module spc_reg_bank #(
    parameter int                DATA_W     = 32,
    parameter int                NUM_REGS   = 8,
    parameter int                ADDR_W     = $clog2(NUM_REGS),
    parameter logic [DATA_W-1:0] PC_RESET   = '0,
    parameter int                PC_STEP    = 4,
    parameter logic [DATA_W-1:0] SP_TOP     = DATA_W'(32'h0000_1000),
    parameter logic [DATA_W-1:0] SP_BOTTOM  = DATA_W'(32'h0000_0800),
    parameter logic [DATA_W-1:0] EXC_VECTOR = DATA_W'(32'h0000_0040)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              usr_wr_en,
    input  logic [ADDR_W-1:0] usr_wr_addr,
    input  logic [DATA_W-1:0] usr_wr_data,
    input  logic [ADDR_W-1:0] usr_rd_addr,
    output logic [DATA_W-1:0] usr_rd_data,
    input  logic [1:0]        pc_mode,
    input  logic [DATA_W-1:0] pc_load_data,
    input  logic [1:0]        sp_op,
    input  logic              lr_wr_en,
    input  logic [DATA_W-1:0] lr_wr_data,
    input  logic [3:0]        flag_wr_mask,
    input  logic [3:0]        flag_wr_data,
    input  logic              exc_enter,
    input  logic              exc_return,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] sp_out,
    output logic [DATA_W-1:0] lr_out,
    output logic [DATA_W-1:0] cpsr_out,
    output logic              in_exception,
    output logic              stack_fault,
    output logic              exc_nested
);

    localparam logic [ADDR_W-1:0] IDX_ZR   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] IDX_SP   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] IDX_LR   = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] IDX_PC   = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] IDX_CPSR = ADDR_W'(7);

    // One extra bit so the SP bounds checks never wrap around zero or 2^DATA_W.
    localparam int                EXT_W    = DATA_W + 1;
    localparam logic [EXT_W-1:0]  SP_STEP  = EXT_W'(DATA_W / 8);
    localparam logic [DATA_W-1:0] PC_INC   = DATA_W'(PC_STEP);

    localparam logic [1:0] PC_ADVANCE = 2'b01;
    localparam logic [1:0] PC_LOAD    = 2'b10;
    localparam logic [1:0] SP_PUSH    = 2'b01;
    localparam logic [1:0] SP_POP     = 2'b10;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] shadow_pc_q, shadow_pc_d;
    logic [DATA_W-1:0] shadow_cpsr_q, shadow_cpsr_d;
    logic              stack_fault_q, stack_fault_d;
    logic              exc_nested_q, exc_nested_d;

    logic              in_exc;
    logic              exc_take;
    logic              exc_leave;
    logic [EXT_W-1:0]  sp_ext;
    logic              push_ok;
    logic              pop_ok;
    logic [DATA_W-1:0] cpsr_flagged;

    assign in_exc    = regs_q[IDX_CPSR][0];
    assign exc_take  = exc_enter & ~in_exc;
    assign exc_leave = exc_return & in_exc;

    assign sp_ext  = {1'b0, regs_q[IDX_SP]};
    assign push_ok = sp_ext >= ({1'b0, SP_BOTTOM} + SP_STEP);
    assign pop_ok  = (sp_ext + SP_STEP) <= {1'b0, SP_TOP};

    // Current CPSR with only the masked NZCV bits replaced; N sits at the MSB.
    always_comb begin
        cpsr_flagged = regs_q[IDX_CPSR];
        for (int i = 0; i < 4; i++) begin
            if (flag_wr_mask[i]) begin
                cpsr_flagged[DATA_W-4+i] = flag_wr_data[i];
            end
        end
    end

    // Next-state: sources are applied lowest priority first so that each later
    // assignment naturally wins arbitration for its register.
    always_comb begin
        regs_d        = regs_q;
        shadow_pc_d   = shadow_pc_q;
        shadow_cpsr_d = shadow_cpsr_q;
        stack_fault_d = 1'b0;
        exc_nested_d  = exc_enter & in_exc;

        if (usr_wr_en && (usr_wr_addr != IDX_ZR)) begin
            regs_d[usr_wr_addr] = usr_wr_data;
        end

        // PC sequencer
        if (pc_mode == PC_ADVANCE) begin
            regs_d[IDX_PC] = regs_q[IDX_PC] + PC_INC;
        end else if (pc_mode == PC_LOAD) begin
            regs_d[IDX_PC] = pc_load_data;
        end
        if (exc_leave) begin
            regs_d[IDX_PC] = shadow_pc_q;
        end
        if (exc_take) begin
            regs_d[IDX_PC] = EXC_VECTOR;
        end

        // A stack op always claims SP, so a rejected op still masks a user write.
        if (sp_op == SP_PUSH) begin
            if (push_ok) begin
                regs_d[IDX_SP] = regs_q[IDX_SP] - SP_STEP[DATA_W-1:0];
            end else begin
                regs_d[IDX_SP] = regs_q[IDX_SP];
                stack_fault_d  = 1'b1;
            end
        end else if (sp_op == SP_POP) begin
            if (pop_ok) begin
                regs_d[IDX_SP] = regs_q[IDX_SP] + SP_STEP[DATA_W-1:0];
            end else begin
                regs_d[IDX_SP] = regs_q[IDX_SP];
                stack_fault_d  = 1'b1;
            end
        end

        if (lr_wr_en) begin
            regs_d[IDX_LR] = lr_wr_data;
        end

        // CPSR: flag update beats the user port, exceptions beat both
        if (flag_wr_mask != 4'b0000) begin
            regs_d[IDX_CPSR] = cpsr_flagged;
        end
        if (exc_leave) begin
            regs_d[IDX_CPSR] = shadow_cpsr_q;
        end
        if (exc_take) begin
            regs_d[IDX_CPSR]    = regs_q[IDX_CPSR] | DATA_W'(1);
            shadow_cpsr_d       = regs_q[IDX_CPSR];
            shadow_pc_d         = regs_q[IDX_PC];
        end

        regs_d[IDX_ZR] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[IDX_PC] <= PC_RESET;
            regs_q[IDX_SP] <= SP_TOP;
            shadow_pc_q    <= '0;
            shadow_cpsr_q  <= '0;
            stack_fault_q  <= 1'b0;
            exc_nested_q   <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            shadow_pc_q   <= shadow_pc_d;
            shadow_cpsr_q <= shadow_cpsr_d;
            stack_fault_q <= stack_fault_d;
            exc_nested_q  <= exc_nested_d;
        end
    end

    assign usr_rd_data  = (usr_rd_addr == IDX_ZR) ? '0 : regs_q[usr_rd_addr];
    assign pc_out       = regs_q[IDX_PC];
    assign sp_out       = regs_q[IDX_SP];
    assign lr_out       = regs_q[IDX_LR];
    assign cpsr_out     = regs_q[IDX_CPSR];
    assign in_exception = in_exc;
    assign stack_fault  = stack_fault_q;
    assign exc_nested   = exc_nested_q;

endmodule

// File: tb/tb_spc_reg_bank.sv
// tb_spc_reg_bank: scoreboard bench for spc_reg_bank with default parameters.
// A reference model predicts the register state after every clock edge and
// queues it; a monitor pops and compares on the falling edge. Directed
// scenarios additionally check known constant values right after an edge.
module tb_spc_reg_bank;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          usr_wr_en;
    logic [2:0]    usr_wr_addr;
    logic [DW-1:0] usr_wr_data;
    logic [2:0]    usr_rd_addr;
    logic [DW-1:0] usr_rd_data;
    logic [1:0]    pc_mode;
    logic [DW-1:0] pc_load_data;
    logic [1:0]    sp_op;
    logic          lr_wr_en;
    logic [DW-1:0] lr_wr_data;
    logic [3:0]    flag_wr_mask;
    logic [3:0]    flag_wr_data;
    logic          exc_enter;
    logic          exc_return;
    logic [DW-1:0] pc_out, sp_out, lr_out, cpsr_out;
    logic          in_exception, stack_fault, exc_nested;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [7:0][DW-1:0] regs;
        logic               fault;
        logic               nested;
    } exp_t;

    exp_t expQ[$];

    logic [DW-1:0] mReg [8];
    logic [DW-1:0] mShadowPc;
    logic [DW-1:0] mShadowCpsr;

    spc_reg_bank dut (
        .clk          (clk),
        .reset        (reset),
        .usr_wr_en    (usr_wr_en),
        .usr_wr_addr  (usr_wr_addr),
        .usr_wr_data  (usr_wr_data),
        .usr_rd_addr  (usr_rd_addr),
        .usr_rd_data  (usr_rd_data),
        .pc_mode      (pc_mode),
        .pc_load_data (pc_load_data),
        .sp_op        (sp_op),
        .lr_wr_en     (lr_wr_en),
        .lr_wr_data   (lr_wr_data),
        .flag_wr_mask (flag_wr_mask),
        .flag_wr_data (flag_wr_data),
        .exc_enter    (exc_enter),
        .exc_return   (exc_return),
        .pc_out       (pc_out),
        .sp_out       (sp_out),
        .lr_out       (lr_out),
        .cpsr_out     (cpsr_out),
        .in_exception (in_exception),
        .stack_fault  (stack_fault),
        .exc_nested   (exc_nested)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mReg[i] = '0;
        mReg[4]     = 32'h0000_1000;
        mShadowPc   = '0;
        mShadowCpsr = '0;
    endtask

    // Applies one clock edge worth of rules to the model and returns the prediction.
    task automatic modelStep(output exp_t e);
        logic [DW-1:0] nxt [8];
        longint        sp;
        logic          inExc, enter, leave;
        nxt   = mReg;
        sp    = longint'(mReg[4]);
        inExc = mReg[7][0];
        enter = exc_enter && !inExc;
        leave = exc_return && inExc;
        e.fault  = 1'b0;
        e.nested = exc_enter && inExc;

        // The user port claims its target unless a stronger source does below.
        if (usr_wr_en && usr_wr_addr != 3'd0) nxt[usr_wr_addr] = usr_wr_data;

        if (enter)              nxt[6] = 32'h0000_0040;
        else if (leave)         nxt[6] = mShadowPc;
        else if (pc_mode == 2)  nxt[6] = pc_load_data;
        else if (pc_mode == 1)  nxt[6] = DW'((longint'(mReg[6]) + 4) % 64'h1_0000_0000);

        if (sp_op == 1 || sp_op == 2) begin
            nxt[4] = mReg[4];
            if (sp_op == 1) begin
                if (sp - 4 >= 64'h800) nxt[4] = DW'(sp - 4);
                else e.fault = 1'b1;
            end else begin
                if (sp + 4 <= 64'h1000) nxt[4] = DW'(sp + 4);
                else e.fault = 1'b1;
            end
        end

        if (lr_wr_en) nxt[5] = lr_wr_data;

        if (enter) begin
            nxt[7]      = mReg[7] | 32'h1;
            mShadowCpsr = mReg[7];
            mShadowPc   = mReg[6];
        end else if (leave) begin
            nxt[7] = mShadowCpsr;
        end else if (flag_wr_mask != 0) begin
            nxt[7] = mReg[7];
            if (flag_wr_mask[3]) nxt[7][31] = flag_wr_data[3];
            if (flag_wr_mask[2]) nxt[7][30] = flag_wr_data[2];
            if (flag_wr_mask[1]) nxt[7][29] = flag_wr_data[1];
            if (flag_wr_mask[0]) nxt[7][28] = flag_wr_data[0];
        end

        nxt[0] = '0;
        mReg = nxt;
        for (int i = 0; i < 8; i++) e.regs[i] = mReg[i];
    endtask

    // Reference model: predicts each edge's outcome and queues it for the monitor.
    always @(posedge clk or posedge reset) begin : modelProc
        exp_t e;
        if (reset) begin
            modelReset();
            expQ.delete();
        end else begin
            modelStep(e);
            expQ.push_back(e);
        end
    end

    // Monitor: compares every predicted edge against the DUT on the falling edge.
    always @(negedge clk) begin : monitorProc
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("mon_pc", pc_out, e.regs[6]);
            checkOutput("mon_sp", sp_out, e.regs[4]);
            checkOutput("mon_lr", lr_out, e.regs[5]);
            checkOutput("mon_cpsr", cpsr_out, e.regs[7]);
            checkOutput("mon_in_exc", DW'(in_exception), DW'(e.regs[7][0]));
            checkOutput("mon_fault", DW'(stack_fault), DW'(e.fault));
            checkOutput("mon_nested", DW'(exc_nested), DW'(e.nested));
            checkOutput("mon_rd", usr_rd_data, e.regs[usr_rd_addr]);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic setIdle();
        usr_wr_en    = 1'b0;
        usr_wr_addr  = '0;
        usr_wr_data  = '0;
        pc_mode      = 2'b00;
        pc_load_data = '0;
        sp_op        = 2'b00;
        lr_wr_en     = 1'b0;
        lr_wr_data   = '0;
        flag_wr_mask = '0;
        flag_wr_data = '0;
        exc_enter    = 1'b0;
        exc_return   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of inputs, lets the edge happen, then returns to idle.
    task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [DW-1:0] wd,
                                 input logic [1:0] pm, input logic [DW-1:0] pd,
                                 input logic [1:0] so, input logic le, input logic [DW-1:0] ld,
                                 input logic [3:0] fm, input logic [3:0] fd,
                                 input logic ee, input logic er);
        usr_wr_en = we;  usr_wr_addr = wa;  usr_wr_data = wd;
        pc_mode = pm;    pc_load_data = pd;  sp_op = so;
        lr_wr_en = le;   lr_wr_data = ld;
        flag_wr_mask = fm; flag_wr_data = fd;
        exc_enter = ee;  exc_return = er;
        tick();
        setIdle();
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        setIdle();
        usr_rd_addr = 3'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("rst_pc", pc_out, 32'h0);
        checkOutput("rst_sp", sp_out, 32'h1000);
        checkOutput("rst_cpsr", cpsr_out, 32'h0);
        checkOutput("rst_fault", DW'(stack_fault), 32'h0);

        // Reach PC=0x20, SP=0xFF8, then assert reset between edges.
        applyStimulus(1, 3'd4, 32'hFF8, 2'b10, 32'h20, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pre_pc", pc_out, 32'h20);
        checkOutput("pre_sp", sp_out, 32'hFF8);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_pc", pc_out, 32'h0);
        checkOutput("async_sp", sp_out, 32'h1000);
        checkOutput("async_cpsr", cpsr_out, 32'h0);
        checkOutput("async_rd_zr", usr_rd_data, 32'h0);
        tick();
        reset = 1'b0;

        // PC sequencing, then a load that beats a same-cycle user write.
        usr_rd_addr = 3'd6;
        applyStimulus(0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pc_adv1", pc_out, 32'h4);
        applyStimulus(0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pc_adv2", pc_out, 32'h8);
        applyStimulus(0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pc_adv3", pc_out, 32'hC);
        applyStimulus(1, 3'd6, 32'h55, 2'b10, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pc_load", pc_out, 32'h100);
        checkOutput("pc_rd", usr_rd_data, 32'h100);

        // Push down to the floor, then one push too many.
        usr_rd_addr = 3'd4;
        for (int i = 0; i < 512; i++) applyStimulus(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        checkOutput("push_floor_sp", sp_out, 32'h800);
        checkOutput("push_floor_nofault", DW'(stack_fault), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        checkOutput("push_over_fault", DW'(stack_fault), 32'h1);
        checkOutput("push_over_sp", sp_out, 32'h800);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fault_one_cycle", DW'(stack_fault), 32'h0);

        // Pop at the ceiling is rejected and also masks a user SP write.
        pulseReset();
        applyStimulus(1, 3'd4, 32'h900, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
        checkOutput("pop_top_fault", DW'(stack_fault), 32'h1);
        checkOutput("pop_top_sp", sp_out, 32'h1000);

        // Masked flag update beats a user CPSR write.
        applyStimulus(1, 3'd7, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 4'b0101, 4'b1111, 0, 0);
        checkOutput("flags_cpsr", cpsr_out, 32'h5000_0000);

        // Exception entry, nested attempt, return.
        applyStimulus(0, 0, 0, 2'b10, 32'h30, 0, 0, 0, 4'b1111, 4'b1010, 0, 0);
        checkOutput("exc_pre_pc", pc_out, 32'h30);
        checkOutput("exc_pre_cpsr", cpsr_out, 32'hA000_0000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("exc_enter_pc", pc_out, 32'h40);
        checkOutput("exc_enter_cpsr", cpsr_out, 32'hA000_0001);
        checkOutput("exc_enter_mode", DW'(in_exception), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("exc_nested_pulse", DW'(exc_nested), 32'h1);
        checkOutput("exc_nested_pc", pc_out, 32'h40);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("exc_nested_clear", DW'(exc_nested), 32'h0);
        checkOutput("exc_ret_pc", pc_out, 32'h30);
        checkOutput("exc_ret_cpsr", cpsr_out, 32'hA000_0000);
        checkOutput("exc_ret_mode", DW'(in_exception), 32'h0);

        // Zero register ignores writes; LR strobe beats the user port.
        usr_rd_addr = 3'd0;
        applyStimulus(1, 3'd0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("zr_read", usr_rd_data, 32'h0);
        usr_rd_addr = 3'd5;
        applyStimulus(1, 3'd5, 32'h777, 0, 0, 0, 1, 32'hBEEF, 0, 0, 0, 0);
        checkOutput("lr_win", lr_out, 32'hBEEF);
        checkOutput("lr_rd", usr_rd_data, 32'hBEEF);

        // Randomised traffic checked only by the scoreboard.
        pulseReset();
        for (int i = 0; i < 2000; i++) begin
            usr_wr_en    = ($urandom_range(0, 1) == 1);
            usr_wr_addr  = 3'($urandom_range(0, 7));
            usr_wr_data  = (usr_wr_addr == 3'd4) ? 32'($urandom_range(32'h7F0, 32'h1010))
                                                 : $urandom;
            usr_rd_addr  = 3'($urandom_range(0, 7));
            pc_mode      = 2'($urandom_range(0, 3));
            pc_load_data = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            sp_op        = 2'($urandom_range(0, 3));
            lr_wr_en     = ($urandom_range(0, 3) == 0);
            lr_wr_data   = $urandom;
            flag_wr_mask = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            flag_wr_data = 4'($urandom_range(0, 15));
            exc_enter    = ($urandom_range(0, 7) == 0);
            exc_return   = ($urandom_range(0, 7) == 0);
            tick();
        end
        setIdle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
